// File: rtl/srsw_mem_tester.sv
// srsw_mem_tester
//   Traffic generator and checker for a simple-dual-port (one read, one write)
//   memory. A run writes a seed-derived byte pattern to every address, reads
//   every address back and counts the words that differ from the pattern.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start, seed     begin a run (accepted only in IDLE or DONE), pattern seed
//   wen/waddr/wdata memory write port (driven in WRITE only, zero otherwise)
//   raddr, rdata    memory read port; rdata is valid one cycle after raddr
//   busy, done      run in progress / results valid
//   pass            done and no mismatching word
//   err_count       mismatching words of the last run
//   first_err_addr  address of the first mismatching word (0 if none)
//
// Handshake: start is a level sampled on the rising edge; it is honoured only
// when the FSM sits in IDLE or DONE and ignored while busy is high.
module srsw_mem_tester #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            seed,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [7:0]            seed_q;
    logic                  cmp_valid;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic                  first_err_seen;
    logic                  mismatch;

    // Byte k of word a is seed + a*DATA_BYTES + k, all modulo 256.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] s,
                                                      input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        logic [7:0]            base;
        w    = '0;
        base = s + 8'(int'(a) * DATA_BYTES);
        for (int k = 0; k < DATA_BYTES; k++) begin
            w[k*8 +: 8] = base + 8'(k);
        end
        return w;
    endfunction

    // cmp_addr names the address the memory latched last cycle, so rdata
    // belongs to it now.
    assign mismatch = cmp_valid && (rdata != pattern(seed_q, cmp_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            seed_q         <= '0;
            cmp_valid      <= 1'b0;
            cmp_addr       <= '0;
            first_err_seen <= 1'b0;
            raddr          <= '0;
            wen            <= 1'b0;
            waddr          <= '0;
            wdata          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            if (mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (!first_err_seen) begin
                    first_err_seen <= 1'b1;
                    first_err_addr <= cmp_addr;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        seed_q         <= seed;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_seen <= 1'b0;
                        cnt            <= '0;
                        state          <= WRITE;
                        // Outputs are registered, so address 0 is presented now
                        // and written on the next edge.
                        wen            <= 1'b1;
                        waddr          <= '0;
                        wdata          <= pattern(seed, '0);
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                WRITE: begin
                    if (cnt == ADDR_LAST) begin
                        cnt   <= '0;
                        state <= READ;
                        wen   <= 1'b0;
                        waddr <= '0;
                        wdata <= '0;
                        raddr <= '0;
                    end else begin
                        cnt   <= cnt + ADDR_ONE;
                        waddr <= cnt + ADDR_ONE;
                        wdata <= pattern(seed_q, cnt + ADDR_ONE);
                    end
                end
                READ: begin
                    // The memory latches raddr (== cnt) on this edge.
                    cmp_valid <= 1'b1;
                    cmp_addr  <= cnt;
                    if (cnt == ADDR_LAST) begin
                        cnt   <= '0;
                        state <= DRAIN;
                        raddr <= '0;
                    end else begin
                        cnt   <= cnt + ADDR_ONE;
                        raddr <= cnt + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    // First edge finishes the last compare; the second
                    // publishes results with err_count already final.
                    if (cmp_valid) begin
                        cmp_valid <= 1'b0;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
